mem_dma_initiator: RTL and testbench

//  Bus initiator for the memory controller's addr/we/wd/rd port: copies a block of words from
//  any mapped region (image ROM 0..152099 or RAM 152100..305735) into RAM without CPU load/stores.

---
 rtl/mem_dma_initiator.sv | 173 +++++++++++++++++
 tb/tb_mem_dma_initiator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_dma_initiator.sv
// Block-copy initiator for the memory controller port: reads a word from src and writes it to dst,
// one word every two cycles. Range-checks the request up front and reports the outcome with a done pulse.
//
// state | meaning
// IDLE  | port released, waiting for start
// READ  | mem_addr = src + words_done, capture mem_rd
// WRITE | mem_addr = dst + words_done, mem_we = 1
// DONE  | one-cycle done pulse, port still owned
module mem_dma_initiator #(
    parameter int unsigned RAM_BASE = 152100,
    parameter int unsigned RAM_LAST = 305735,
    parameter int unsigned LEN_W    = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_base,
    input  logic [31:0]      dst_base,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] words_done,
    output logic [31:0]      mem_addr,
    output logic             mem_we,
    output logic [31:0]      mem_wd,
    input  logic [31:0]      mem_rd
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [32:0] RAM_BASE_X = 33'(RAM_BASE);
    localparam logic [32:0] RAM_LAST_X = 33'(RAM_LAST);

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [LEN_W-1:0]   words_done_q, words_done_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_wd_q, mem_wd_d;

    logic [32:0]        dst_end, src_end;
    logic               range_fail;
    logic [LEN_W-1:0]   wd_inc;
    logic [31:0]        wd_ext, wd_inc_ext;

    // End addresses in 33 bits so a request near 2^32 cannot wrap past the check.
    assign dst_end    = {1'b0, dst_base} + {{(33-LEN_W){1'b0}}, len} - 33'd1;
    assign src_end    = {1'b0, src_base} + {{(33-LEN_W){1'b0}}, len} - 33'd1;
    assign range_fail = ({1'b0, dst_base} < RAM_BASE_X) ||
                        (dst_end > RAM_LAST_X) ||
                        (src_end > RAM_LAST_X);

    assign wd_inc     = words_done_q + {{(LEN_W-1){1'b0}}, 1'b1};
    assign wd_ext     = {{(32-LEN_W){1'b0}}, words_done_q};
    assign wd_inc_ext = {{(32-LEN_W){1'b0}}, wd_inc};

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        words_done_d = words_done_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wd_d     = mem_wd_q;

        case (state_q)
            IDLE: begin
                busy_d     = 1'b0;
                mem_addr_d = 32'd0;
                if (start) begin
                    src_d        = src_base;
                    dst_d        = dst_base;
                    len_d        = len;
                    words_done_d = '0;
                    error_d      = 1'b0;
                    busy_d       = 1'b1;
                    if (len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (range_fail) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end else begin
                        state_d    = READ;
                        mem_addr_d = src_base;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    mem_addr_d = 32'd0;
                end else begin
                    state_d    = WRITE;
                    mem_wd_d   = mem_rd;
                    mem_we_d   = 1'b1;
                    mem_addr_d = dst_q + wd_ext;
                end
            end
            WRITE: begin
                words_done_d = wd_inc;
                if ((wd_inc == len_q) || abort) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    mem_addr_d = 32'd0;
                end else begin
                    state_d    = READ;
                    mem_addr_d = src_q + wd_inc_ext;
                end
            end
            DONE: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                mem_addr_d = 32'd0;
            end
            default: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                mem_addr_d = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            src_q        <= 32'd0;
            dst_q        <= 32'd0;
            len_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_done_q <= '0;
            mem_addr_q   <= 32'd0;
            mem_we_q     <= 1'b0;
            mem_wd_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            words_done_q <= words_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wd_q     <= mem_wd_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_done = words_done_q;
    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_mem_dma_initiator.sv
// Directed bench for mem_dma_initiator: a behavioural ROM/RAM array answers the port, and each
// transfer is checked for completion cycle, write count, words_done, error and copied data.
module tb_mem_dma_initiator;

    localparam int RAM_BASE = 152100;
    localparam int RAM_LAST = 305735;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src_base = 32'd0;
    logic [31:0] dst_base = 32'd0;
    logic [17:0] len = 18'd0;
    logic        abort = 1'b0;
    logic        busy, done, error;
    logic [17:0] words_done;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_we;

    logic [31:0] mem [0:RAM_LAST];
    int          wr_cnt = 0;
    int          illegal = 0;
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    mem_dma_initiator dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .dst_base(dst_base),
        .len(len), .abort(abort), .busy(busy), .done(done), .error(error),
        .words_done(words_done), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    assign mem_rd = (mem_addr <= 32'(RAM_LAST)) ? mem[mem_addr[18:0]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr >= 32'(RAM_BASE) && mem_addr <= 32'(RAM_LAST))
                mem[mem_addr[18:0]] <= mem_wd;
            else
                illegal <= illegal + 1;
            wr_cnt <= wr_cnt + 1;
        end
        if (busy && mem_addr > 32'(RAM_LAST))
            illegal <= illegal + 1;
    end

    function automatic logic [31:0] pat(input int a);
        return (32'(a) * 32'd2654435761) ^ 32'h0F0F_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one transfer; ab/rs give the cycle in which abort or a stray start is driven (0 = none).
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [17:0] l,
                       input int ab, input int rs, output int dc, output int nw);
        int base;
        int budget;
        logic found;
        @(negedge clk);
        base = wr_cnt;
        src_base = s; dst_base = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        budget = 2 * int'(l) + 10;
        found = 1'b0;
        dc = 0;
        for (int cyc = 1; cyc <= budget && !found; cyc++) begin
            @(negedge clk);
            abort = 1'b0;
            start = 1'b0;
            if (done) begin
                found = 1'b1;
                dc = cyc;
            end else begin
                if (cyc == ab) abort = 1'b1;
                if (cyc == rs) begin
                    src_base = 32'd5; dst_base = 32'd200000; len = 18'd0; start = 1'b1;
                end
            end
        end
        abort = 1'b0;
        start = 1'b0;
        check("timeout", 32'(found), 32'd1);
        nw = wr_cnt - base;
    endtask

    int dc, nw, wb;

    initial begin
        for (int a = 0; a <= RAM_LAST; a++)
            mem[a] = (a < RAM_BASE) ? pat(a) : ~pat(a);

        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wd", mem_wd, 32'd0);
        check("rst_words", 32'(words_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ROM -> RAM, 4 words
        run(32'd0, 32'd152100, 18'd4, 0, 0, dc, nw);
        check("rom_done_cyc", 32'(dc), 32'd9);
        check("rom_writes", 32'(nw), 32'd4);
        check("rom_error", 32'(error), 32'd0);
        check("rom_words", 32'(words_done), 32'd4);
        check("rom_busy_dn", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++)
            check($sformatf("rom_data%0d", i), mem[RAM_BASE + i], pat(i));
        @(negedge clk);
        check("rom_busy_after", 32'(busy), 32'd0);
        check("rom_done_pulse", 32'(done), 32'd0);

        // len = 0
        run(32'd0, 32'd152100, 18'd0, 0, 0, dc, nw);
        check("len0_done_cyc", 32'(dc), 32'd1);
        check("len0_writes", 32'(nw), 32'd0);
        check("len0_error", 32'(error), 32'd0);
        check("len0_words", 32'(words_done), 32'd0);

        // Range failures
        run(32'd0, 32'd100, 18'd1, 0, 0, dc, nw);
        check("rng_rom_cyc", 32'(dc), 32'd1);
        check("rng_rom_error", 32'(error), 32'd1);
        check("rng_rom_writes", 32'(nw), 32'd0);
        run(32'd0, 32'd305735, 18'd2, 0, 0, dc, nw);
        check("rng_end_cyc", 32'(dc), 32'd1);
        check("rng_end_error", 32'(error), 32'd1);
        check("rng_end_writes", 32'(nw), 32'd0);
        repeat (3) @(negedge clk);
        check("rng_err_held", 32'(error), 32'd1);
        run(32'd305735, 32'd200000, 18'd2, 0, 0, dc, nw);
        check("rng_src_error", 32'(error), 32'd1);
        check("rng_src_writes", 32'(nw), 32'd0);

        // Last ROM word to last RAM word
        run(32'd152099, 32'd305735, 18'd1, 0, 0, dc, nw);
        check("last_cyc", 32'(dc), 32'd3);
        check("last_error", 32'(error), 32'd0);
        check("last_writes", 32'(nw), 32'd1);
        check("last_data", mem[RAM_LAST], pat(152099));

        // Abort during the third WRITE (cycle 6)
        run(32'd10, 32'd160000, 18'd10, 6, 0, dc, nw);
        check("abw_cyc", 32'(dc), 32'd7);
        check("abw_words", 32'(words_done), 32'd3);
        check("abw_writes", 32'(nw), 32'd3);
        check("abw_error", 32'(error), 32'd0);
        check("abw_data2", mem[160002], pat(12));
        check("abw_nowrite3", mem[160003], ~pat(160003));

        // Abort during the second READ (cycle 3)
        run(32'd20, 32'd170000, 18'd10, 3, 0, dc, nw);
        check("abr_cyc", 32'(dc), 32'd4);
        check("abr_words", 32'(words_done), 32'd1);
        check("abr_writes", 32'(nw), 32'd1);

        // Start while busy is ignored
        run(32'd30, 32'd180000, 18'd4, 0, 3, dc, nw);
        check("bsy_cyc", 32'(dc), 32'd9);
        check("bsy_words", 32'(words_done), 32'd4);
        check("bsy_writes", 32'(nw), 32'd4);
        check("bsy_data3", mem[180003], pat(33));
        @(negedge clk);
        check("bsy_not_queued", 32'(busy), 32'd0);

        // Reset during a WRITE
        @(negedge clk);
        wb = wr_cnt;
        src_base = 32'd40; dst_base = 32'd190000; len = 18'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("rstw_in_write", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_we", 32'(mem_we), 32'd0);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_addr", mem_addr, 32'd0);
        check("rstw_words", 32'(words_done), 32'd0);
        check("rstw_writes", 32'(wr_cnt - wb), 32'd1);
        check("rstw_kept", mem[190000], pat(40));
        @(negedge clk);
        rst_n = 1'b1;
        run(32'd50, 32'd195000, 18'd2, 0, 0, dc, nw);
        check("post_rst_cyc", 32'(dc), 32'd5);
        check("post_rst_writes", 32'(nw), 32'd2);

        check("illegal_access", 32'(illegal), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
